handshaked_fifo: RTL and testbench

HANDSHAKED_FIFO -- requirements
Module: handshaked_fifo

---
 rtl/handshaked_fifo.sv | 85 ++++++++
 tb/tb_handshaked_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/handshaked_fifo.sv
// Circular-buffer FIFO with valid/ready handshakes on both sides and a size count.
// Optional build: HANDSHAKED_FIFO_FALL_THROUGH_EN lets a word pass straight through when the FIFO is empty.
module handshaked_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        dataIn_data,
    input  logic                         dataIn_vld,
    output logic                         dataIn_rd,
    output logic [DATA_WIDTH-1:0]        dataOut_data,
    output logic                         dataOut_vld,
    input  logic                         dataOut_rd,
    output logic [$clog2(DEPTH+1)-1:0]   size
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(DEPTH+1);

    // Handshake: a word moves on a side only when that side's vld and rd are both 1 at the rising clk edge.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [SW-1:0]         size_q, size_d;
    logic                  full, empty;
    logic                  wr_en, rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (size_q == SW'(DEPTH));
    assign empty = (size_q == '0);

    assign dataIn_rd = !full;
    assign size      = size_q;

`ifdef HANDSHAKED_FIFO_FALL_THROUGH_EN
    logic bypass;

    // An empty FIFO hands the incoming word straight to a ready consumer without storing it.
    assign bypass       = empty && dataIn_vld && dataOut_rd;
    assign wr_en        = dataIn_vld && !full && !bypass;
    assign rd_en        = dataOut_rd && !empty;
    assign dataOut_vld  = empty ? dataIn_vld  : 1'b1;
    assign dataOut_data = empty ? dataIn_data : mem_q[rd_ptr_q];
`else
    assign wr_en        = dataIn_vld && !full;
    assign rd_en        = dataOut_rd && !empty;
    assign dataOut_vld  = !empty;
    assign dataOut_data = mem_q[rd_ptr_q];
`endif

    always_comb begin
        wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        size_d   = size_q;
        case ({wr_en, rd_en})
            2'b10:   size_d = size_q + 1'b1;
            2'b01:   size_d = size_q - 1'b1;
            default: size_d = size_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= dataIn_data;
        end
    end

endmodule

// File: tb/tb_handshaked_fifo.sv
// Directed bench for handshaked_fifo (DEPTH=4, DATA_WIDTH=8) with a count/queue reference model.
module tb_handshaked_fifo;

    localparam int DW = 8;
    localparam int DP = 4;
`ifdef HANDSHAKED_FIFO_FALL_THROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [DW-1:0] din_data;
    logic          din_vld;
    logic          din_rd;
    logic [DW-1:0] dout_data;
    logic          dout_vld;
    logic          dout_rd;
    logic [2:0]    size;

    int            errors;
    int            checks;
    int            model_cnt;
    logic [DW-1:0] exp_q[$];

    handshaked_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .dataIn_data  (din_data),
        .dataIn_vld   (din_vld),
        .dataIn_rd    (din_rd),
        .dataOut_data (dout_data),
        .dataOut_vld  (dout_vld),
        .dataOut_rd   (dout_rd),
        .size         (size)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge, check outputs against the model, update the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        output logic acc_in, output logic acc_out);
        logic bypass;
        @(negedge clk);
        din_vld  = v;
        din_data = d;
        dout_rd  = r;
        #1;
        check("in_rd", {31'd0, din_rd}, {31'd0, model_cnt < DP});
        check("out_vld", {31'd0, dout_vld}, {31'd0, (model_cnt != 0) || (FT && v)});
        check("size", {29'd0, size}, model_cnt);
        if (model_cnt != 0)
            check("head", {24'd0, dout_data}, {24'd0, exp_q[0]});
        else if (FT && v)
            check("bypass_data", {24'd0, dout_data}, {24'd0, d});
        bypass  = FT && (model_cnt == 0) && v && r;
        acc_in  = v && (model_cnt < DP) && !bypass;
        acc_out = r && (model_cnt != 0);
        if (acc_out) void'(exp_q.pop_front());
        if (acc_in) exp_q.push_back(d);
        model_cnt = model_cnt + (acc_in ? 1 : 0) - (acc_out ? 1 : 0);
    endtask

    initial begin
        logic ai, ao;
        int   sent, rcvd;
        errors    = 0;
        checks    = 0;
        model_cnt = 0;
        rst       = 1'b1;
        din_vld   = 1'b0;
        din_data  = '0;
        dout_rd   = 1'b0;
        #2;
        check("rst_size", {29'd0, size}, 0);
        check("rst_out_vld", {31'd0, dout_vld}, 0);
        check("rst_in_rd", {31'd0, din_rd}, 1);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then offer a fifth word that must be refused.
        step(1'b1, 8'h11, 1'b0, ai, ao);
        step(1'b1, 8'h22, 1'b0, ai, ao);
        step(1'b1, 8'h33, 1'b0, ai, ao);
        step(1'b1, 8'h44, 1'b0, ai, ao);
        step(1'b1, 8'h55, 1'b0, ai, ao);
        check("full_size", {29'd0, size}, 4);
        check("full_in_rd", {31'd0, din_rd}, 0);
        check("full_head", {24'd0, dout_data}, 32'h11);

        // One read from full frees a slot on the next cycle.
        step(1'b0, 8'h00, 1'b1, ai, ao);
        check("full_read_data", {24'd0, dout_data}, 32'h11);
        step(1'b0, 8'h00, 1'b0, ai, ao);
        check("after_read_in_rd", {31'd0, din_rd}, 1);
        check("after_read_size", {29'd0, size}, 3);
        check("after_read_head", {24'd0, dout_data}, 32'h22);

        // Asynchronous reset away from any clock edge with three words held.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_size", {29'd0, size}, 0);
        check("async_rst_out_vld", {31'd0, dout_vld}, 0);
        check("async_rst_in_rd", {31'd0, din_rd}, 1);
        model_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;

        // Streaming: one word in and one out per cycle once the first has landed.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b1, ai, ao);
            if (!FT && i > 0) begin
                check("stream_data", {24'd0, dout_data}, i - 1);
                check("stream_size", {29'd0, size}, 1);
            end
        end
        step(1'b0, 8'h00, 1'b1, ai, ao);
        step(1'b0, 8'h00, 1'b0, ai, ao);
        check("stream_drained", {29'd0, size}, 0);

        // Twelve words through random consumer stalls, wrapping the pointers several times.
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 300 && rcvd < 12; c++) begin
            step(sent < 12, 8'hC0 + 8'(sent), 1'($urandom_range(0, 1)), ai, ao);
            if (ai) sent++;
            if (ao || (FT && din_vld && dout_rd && model_cnt == 0 && !ai && sent < 12)) begin
                rcvd++;
                if (!ao) sent++;
            end
        end
        check("wrap_received", rcvd, 12);
        step(1'b0, 8'h00, 1'b0, ai, ao);
        check("wrap_empty", {29'd0, size}, 0);

`ifdef HANDSHAKED_FIFO_FALL_THROUGH_EN
        // Empty FIFO with a ready consumer passes the word in the same cycle.
        step(1'b1, 8'hA5, 1'b1, ai, ao);
        check("ft_data", {24'd0, dout_data}, 32'hA5);
        check("ft_vld", {31'd0, dout_vld}, 1);
        step(1'b0, 8'h00, 1'b0, ai, ao);
        check("ft_size", {29'd0, size}, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
